// File: rtl/timer_loader.sv
// Streams a preset table into the timer load port after a start pulse, then
// waits for the timer's ready flag and reports done or a timeout error.
module timer_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 1,
  parameter int ADR_WIDTH  = 1,
  parameter int GAP        = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [ADR_WIDTH-1:0]  cfg_adr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] tim_tdata,
  output logic                  tim_tvalid,
  input  logic                  tim_tready,
  input  logic                  tim_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_GAP  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] preset_q [NUM_WORDS];
  logic [IDX_W-1:0]      idx_nxt;
  logic [DATA_WIDTH-1:0] cur_word, nxt_word;
  logic                  idle_like;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign idx_nxt   = idx_q + IDX_W'(1);

  // Table is deliberately outside reset; out-of-range addresses match no entry.
  always_ff @(posedge clk) begin
    if (cfg_we && idle_like) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (cfg_adr == ADR_WIDTH'(i)) preset_q[i] <= cfg_data;
      end
    end
  end

  always_comb begin
    cur_word = '0;
    nxt_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx_q == IDX_W'(i))   cur_word = preset_q[i];
      if (idx_nxt == IDX_W'(i)) nxt_word = preset_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_SEND;
          idx_d    = '0;
          tvalid_d = 1'b1;
          tdata_d  = preset_q[0];
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_SEND: begin
        if (tvalid_q && tim_tready) begin
          if (idx_q == IDX_LAST) begin
            state_d  = S_WAIT;
            tvalid_d = 1'b0;
            tmo_d    = '0;
          end else if (GAP == 0) begin
            idx_d   = idx_nxt;
            tdata_d = nxt_word;
          end else begin
            state_d  = S_GAP;
            idx_d    = idx_nxt;
            gap_d    = '0;
            tvalid_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        // idx_q already points at the next word while idling.
        if (gap_q == GAP_LAST) begin
          state_d  = S_SEND;
          tvalid_d = 1'b1;
          tdata_d  = cur_word;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_WAIT: begin
        if (tim_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          tmo_d   = tmo_q + TMO_W'(1);
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign tim_tdata  = tdata_q;
  assign tim_tvalid = tvalid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_timer_loader.sv
// Directed bench: a 3-word back-to-back loader and a 2-word loader with GAP=2.
module tb_timer_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Loader A: NUM_WORDS=3, GAP=0, TIMEOUT=4, ADR_WIDTH=3
  logic       a_cfg_we = 1'b0;
  logic [2:0] a_cfg_adr = 3'd0;
  logic [7:0] a_cfg_data = 8'h00;
  logic       a_start = 1'b0;
  logic [7:0] a_tdata;
  logic       a_tvalid;
  logic       a_tready = 1'b1;
  logic       a_tim_ready = 1'b0;
  logic       a_busy, a_done, a_err;

  // Loader B: NUM_WORDS=2, GAP=2, TIMEOUT=16, ADR_WIDTH=1
  logic       b_cfg_we = 1'b0;
  logic [0:0] b_cfg_adr = 1'b0;
  logic [7:0] b_cfg_data = 8'h00;
  logic       b_start = 1'b0;
  logic [7:0] b_tdata;
  logic       b_tvalid;
  logic       b_tim_ready = 1'b0;
  logic       b_busy, b_done, b_err;

  timer_loader #(.DATA_WIDTH(8), .NUM_WORDS(3), .ADR_WIDTH(3), .GAP(0), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .cfg_we(a_cfg_we), .cfg_adr(a_cfg_adr), .cfg_data(a_cfg_data),
    .start(a_start), .tim_tdata(a_tdata), .tim_tvalid(a_tvalid), .tim_tready(a_tready),
    .tim_ready(a_tim_ready), .busy(a_busy), .done(a_done), .err(a_err)
  );

  timer_loader #(.DATA_WIDTH(8), .NUM_WORDS(2), .ADR_WIDTH(1), .GAP(2), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_adr(b_cfg_adr), .cfg_data(b_cfg_data),
    .start(b_start), .tim_tdata(b_tdata), .tim_tvalid(b_tvalid), .tim_tready(1'b1),
    .tim_ready(b_tim_ready), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [2:0] adr, input logic [7:0] data);
    a_cfg_we = 1'b1; a_cfg_adr = adr; a_cfg_data = data;
    step();
    a_cfg_we = 1'b0;
  endtask

  task automatic a_beat(input string tag, input logic [7:0] data);
    chk({tag, "_tvalid"}, {31'd0, a_tvalid}, 32'd1);
    chk({tag, "_tdata"}, {24'd0, a_tdata}, {24'd0, data});
    chk({tag, "_busy"}, {31'd0, a_busy}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_tvalid", {31'd0, a_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, a_tdata}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_b_tvalid", {31'd0, b_tvalid}, 32'd0);

    a_write(3'd0, 8'h11);
    a_write(3'd1, 8'h22);
    a_write(3'd2, 8'h33);
    a_write(3'd5, 8'hAA);

    // Basic back-to-back stream
    a_start = 1'b1; step(); a_start = 1'b0;
    a_beat("s1_b0", 8'h11);
    step(); a_beat("s1_b1", 8'h22);
    step(); a_beat("s1_b2", 8'h33);
    step();
    chk("s1_wait_tvalid", {31'd0, a_tvalid}, 32'd0);
    chk("s1_wait_busy", {31'd0, a_busy}, 32'd1);
    step();
    a_tim_ready = 1'b1; step(); a_tim_ready = 1'b0;
    chk("s1_done", {31'd0, a_done}, 32'd1);
    chk("s1_done_busy", {31'd0, a_busy}, 32'd0);
    step();
    chk("s1_done_hold", {31'd0, a_done}, 32'd1);

    // Backpressure on the middle beat, plus a write attempt while sending
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("s2_done_clr", {31'd0, a_done}, 32'd0);
    a_beat("s2_b0", 8'h11);
    step(); a_beat("s2_b1a", 8'h22);
    a_tready = 1'b0;
    a_cfg_we = 1'b1; a_cfg_adr = 3'd1; a_cfg_data = 8'hAA;
    step(); a_beat("s2_b1b", 8'h22);
    a_cfg_we = 1'b0;
    step(); a_beat("s2_b1c", 8'h22);
    a_tready = 1'b1;
    step(); a_beat("s2_b2", 8'h33);
    step();
    chk("s2_wait_tvalid", {31'd0, a_tvalid}, 32'd0);

    // Timeout: WAIT entered now, err must rise four cycles later
    step(); step(); step();
    chk("s3_pre_err", {31'd0, a_err}, 32'd0);
    chk("s3_pre_busy", {31'd0, a_busy}, 32'd1);
    step();
    chk("s3_err", {31'd0, a_err}, 32'd1);
    chk("s3_err_done", {31'd0, a_done}, 32'd0);
    chk("s3_err_busy", {31'd0, a_busy}, 32'd0);

    // Restart from ERR clears err and replays the untouched table
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("s4_err_clr", {31'd0, a_err}, 32'd0);
    a_beat("s4_b0", 8'h11);
    step(); a_beat("s4_b1", 8'h22);
    step(); a_beat("s4_b2", 8'h33);
    step();
    // Ready on the final timeout cycle wins over err
    step(); step(); step();
    a_tim_ready = 1'b1; step(); a_tim_ready = 1'b0;
    chk("s4_ready_wins_done", {31'd0, a_done}, 32'd1);
    chk("s4_ready_wins_err", {31'd0, a_err}, 32'd0);

    // Reset while beat 1 is presented
    a_start = 1'b1; step(); a_start = 1'b0;
    a_beat("s5_b0", 8'h11);
    step(); a_beat("s5_b1", 8'h22);
    rst = 1'b1; step(); rst = 1'b0;
    chk("s5_rst_tvalid", {31'd0, a_tvalid}, 32'd0);
    chk("s5_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("s5_rst_done", {31'd0, a_done}, 32'd0);
    step();
    chk("s5_idle_tvalid", {31'd0, a_tvalid}, 32'd0);
    a_start = 1'b1; step(); a_start = 1'b0;
    a_beat("s6_b0", 8'h11);
    step(); a_beat("s6_b1", 8'h22);
    step(); a_beat("s6_b2", 8'h33);
    step();
    chk("s6_no_overrun", {31'd0, a_tvalid}, 32'd0);
    step();
    chk("s6_still_idle_bus", {31'd0, a_tvalid}, 32'd0);

    // Loader B: gap pattern 1,0,0,1
    b_cfg_we = 1'b1; b_cfg_adr = 1'b0; b_cfg_data = 8'h11; step();
    b_cfg_adr = 1'b1; b_cfg_data = 8'h22; step();
    b_cfg_we = 1'b0;
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("g_c0_tvalid", {31'd0, b_tvalid}, 32'd1);
    chk("g_c0_tdata", {24'd0, b_tdata}, 32'h11);
    step();
    chk("g_c1_tvalid", {31'd0, b_tvalid}, 32'd0);
    chk("g_c1_busy", {31'd0, b_busy}, 32'd1);
    step();
    chk("g_c2_tvalid", {31'd0, b_tvalid}, 32'd0);
    step();
    chk("g_c3_tvalid", {31'd0, b_tvalid}, 32'd1);
    chk("g_c3_tdata", {24'd0, b_tdata}, 32'h22);
    step();
    chk("g_wait_tvalid", {31'd0, b_tvalid}, 32'd0);
    chk("g_wait_busy", {31'd0, b_busy}, 32'd1);
    b_tim_ready = 1'b1; step(); b_tim_ready = 1'b0;
    chk("g_done", {31'd0, b_done}, 32'd1);
    chk("g_done_err", {31'd0, b_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
